// File: rtl/nor_flash_arbiter.sv
// Two-port Wishbone arbiter in front of a 16-bit NOR flash (read-only).
// Round-robin grant, fixed access time, one-cycle ack, flash released between accesses.
`timescale 1ns/1ps
module nor_flash_arbiter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        s0_cyc_i,
    input  logic        s0_stb_i,
    input  logic        s0_we_i,
    input  logic [21:1] s0_adr_i,
    output logic [15:0] s0_dat_o,
    output logic        s0_ack_o,
    input  logic        s1_cyc_i,
    input  logic        s1_stb_i,
    input  logic        s1_we_i,
    input  logic [21:1] s1_adr_i,
    output logic [15:0] s1_dat_o,
    output logic        s1_ack_o,
    output logic [21:1] NF_A,
    input  logic [15:0] NF_D,
    output logic        NF_CE,
    output logic        NF_OE,
    output logic        NF_WE,
    output logic        NF_BYTE,
    output logic        NF_RP
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_gnt, w_gnt_nxt;
    logic             r_last, w_last_nxt;
    logic             r_we, w_we_nxt;
    logic             r_abort, w_abort_nxt;
    logic [21:1]      r_a, w_a_nxt;
    logic             r_ce, w_ce_nxt;
    logic             r_oe, w_oe_nxt;
    logic             r_rp;
    logic [15:0]      r_dat0, w_dat0_nxt;
    logic [15:0]      r_dat1, w_dat1_nxt;
    logic             r_ack0, w_ack0_nxt;
    logic             r_ack1, w_ack1_nxt;

    logic w_req0, w_req1, w_gnt_req, w_pick, w_abort_now;

    assign w_req0      = s0_cyc_i & s0_stb_i;
    assign w_req1      = s1_cyc_i & s1_stb_i;
    assign w_gnt_req   = r_gnt ? w_req1 : w_req0;
    // Round-robin: on contention the port not served last wins.
    assign w_pick      = (w_req0 & w_req1) ? ~r_last : w_req1;
    // An access is abandoned once the granted master lets go at any point.
    assign w_abort_now = r_abort | ~w_gnt_req;

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_we_nxt    = r_we;
        w_abort_nxt = r_abort;
        w_a_nxt     = r_a;
        w_ce_nxt    = 1'b1;
        w_oe_nxt    = 1'b1;
        w_dat0_nxt  = r_dat0;
        w_dat1_nxt  = r_dat1;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_state_nxt = ST_ACCESS;
                    w_gnt_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                    w_we_nxt    = w_pick ? s1_we_i : s0_we_i;
                    w_a_nxt     = w_pick ? s1_adr_i : s0_adr_i;
                    w_cnt_nxt   = CNT_LOAD;
                    w_abort_nxt = 1'b0;
                    w_ce_nxt    = 1'b0;
                    w_oe_nxt    = w_we_nxt;
                end
            end
            ST_ACCESS: begin
                w_abort_nxt = w_abort_now;
                w_ce_nxt    = 1'b0;
                w_oe_nxt    = r_we;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                    w_ce_nxt    = 1'b1;
                    w_oe_nxt    = 1'b1;
                    if (!r_we && !w_abort_now) begin
                        if (r_gnt) w_dat1_nxt = NF_D;
                        else       w_dat0_nxt = NF_D;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                if (!w_abort_now) begin
                    w_ack0_nxt = ~r_gnt;
                    w_ack1_nxt = r_gnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the flash idle and in powerdown.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_abort <= 1'b0;
            r_a     <= '0;
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_rp    <= 1'b0;
            r_dat0  <= '0;
            r_dat1  <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_we    <= w_we_nxt;
            r_abort <= w_abort_nxt;
            r_a     <= w_a_nxt;
            r_ce    <= w_ce_nxt;
            r_oe    <= w_oe_nxt;
            r_rp    <= 1'b1;
            r_dat0  <= w_dat0_nxt;
            r_dat1  <= w_dat1_nxt;
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
        end
    end

    assign NF_A     = r_a;
    assign NF_CE    = r_ce;
    assign NF_OE    = r_oe;
    assign NF_WE    = 1'b1;
    assign NF_BYTE  = 1'b1;
    assign NF_RP    = r_rp;
    assign s0_dat_o = r_dat0;
    assign s1_dat_o = r_dat1;
    assign s0_ack_o = r_ack0;
    assign s1_ack_o = r_ack1;

endmodule

// File: tb/tb_nor_flash_arbiter.sv
// Bench for nor_flash_arbiter: directed vectors, corner sequences, and random
// traffic checked every cycle against a transaction-timeline model.
`timescale 1ns/1ps
module tb_nor_flash_arbiter;

    localparam int WAIT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [21:1] adr [2];
    logic [15:0] s0_dat_o, s1_dat_o;
    logic        s0_ack_o, s1_ack_o;
    logic [21:1] NF_A;
    logic [15:0] nf_d;
    logic        NF_CE, NF_OE, NF_WE, NF_BYTE, NF_RP;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    // Flash contents: one fixed word plus an address hash everywhere else.
    function automatic logic [15:0] flash_word(input logic [21:1] a);
        if (a == 21'h00100) return 16'hF4E8;
        return a[16:1] ^ {a[21:17], 11'h2B5} ^ 16'h3C96;
    endfunction

    assign nf_d = flash_word(NF_A);

    nor_flash_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .s0_cyc_i (cyc[0]),
        .s0_stb_i (stb[0]),
        .s0_we_i  (we[0]),
        .s0_adr_i (adr[0]),
        .s0_dat_o (s0_dat_o),
        .s0_ack_o (s0_ack_o),
        .s1_cyc_i (cyc[1]),
        .s1_stb_i (stb[1]),
        .s1_we_i  (we[1]),
        .s1_adr_i (adr[1]),
        .s1_dat_o (s1_dat_o),
        .s1_ack_o (s1_ack_o),
        .NF_A     (NF_A),
        .NF_D     (nf_d),
        .NF_CE    (NF_CE),
        .NF_OE    (NF_OE),
        .NF_WE    (NF_WE),
        .NF_BYTE  (NF_BYTE),
        .NF_RP    (NF_RP)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: an access occupies WAIT+1 edges after its grant edge; data lands on
    // edge WAIT, ack on edge WAIT+1, unless the master let go in between.
    bit          m_busy  = 1'b0;
    bit          m_port  = 1'b0;
    bit          m_last  = 1'b1;
    bit          m_we    = 1'b0;
    bit          m_abort = 1'b0;
    bit          m_rp    = 1'b0;
    int          m_k     = 0;
    logic [21:1] m_addr  = '0;
    logic [15:0] m_dat [2];
    bit          m_ack [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_rp = 1'b0; m_k = 0; m_addr = '0;
            m_dat[0] = '0; m_dat[1] = '0; m_ack[0] = 1'b0; m_ack[1] = 1'b0;
        end else begin
            m_rp = 1'b1;
            m_ack[0] = 1'b0;
            m_ack[1] = 1'b0;
            if (m_busy) begin
                m_k++;
                if (!(cyc[m_port] && stb[m_port])) m_abort = 1'b1;
                if (m_k == WAIT && !m_abort && !m_we) m_dat[m_port] = flash_word(m_addr);
                if (m_k == WAIT + 1) begin
                    m_ack[m_port] = !m_abort;
                    m_busy = 1'b0;
                end
            end else if ((cyc[0] && stb[0]) || (cyc[1] && stb[1])) begin
                if ((cyc[0] && stb[0]) && (cyc[1] && stb[1])) m_port = !m_last;
                else                                          m_port = cyc[1] && stb[1];
                m_last  = m_port;
                m_busy  = 1'b1;
                m_k     = 0;
                m_abort = 1'b0;
                m_addr  = adr[m_port];
                m_we    = we[m_port];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic e_ce, e_oe;
        e_ce = !(m_busy && m_k < WAIT);
        e_oe = !(m_busy && m_k < WAIT && !m_we);
        chk("cyc NF_CE", 32'(NF_CE), 32'(e_ce));
        chk("cyc NF_OE", 32'(NF_OE), 32'(e_oe));
        chk("cyc NF_WE", 32'(NF_WE), 32'd1);
        chk("cyc NF_BYTE", 32'(NF_BYTE), 32'd1);
        chk("cyc NF_RP", 32'(NF_RP), 32'(m_rp));
        chk("cyc NF_A", 32'(NF_A), 32'(m_addr));
        chk("cyc s0_dat", 32'(s0_dat_o), 32'(m_dat[0]));
        chk("cyc s1_dat", 32'(s1_dat_o), 32'(m_dat[1]));
        chk("cyc s0_ack", 32'(s0_ack_o), 32'(m_ack[0]));
        chk("cyc s1_ack", 32'(s1_ack_o), 32'(m_ack[1]));
        chk("cyc ack excl", 32'(s0_ack_o & s1_ack_o), 32'd0);
    end

    task automatic drop_all();
        for (int p = 0; p < 2; p++) begin
            cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
        end
    endtask

    task automatic do_reset();
        drop_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One transaction from IDLE: latency, strobe widths and returned data.
    task automatic run_one(input bit p, input bit w, input logic [21:1] a,
                           input logic [15:0] exp_d, input string tag);
        int  n, ce_lo, oe_lo;
        bit  got;
        n = 0; ce_lo = 0; oe_lo = 0; got = 1'b0;
        cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w; adr[p] = a;
        while (!got && n < 40) begin
            tick();
            n++;
            if (!NF_CE) ce_lo++;
            if (!NF_OE) oe_lo++;
            if (p ? s1_ack_o : s0_ack_o) got = 1'b1;
        end
        cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
        chk({tag, " ack seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(n - 1), 32'(WAIT + 1));
        chk({tag, " ce low cycles"}, 32'(ce_lo), 32'(WAIT));
        chk({tag, " oe low cycles"}, 32'(oe_lo), w ? 32'd0 : 32'(WAIT));
        chk({tag, " dat"}, 32'(p ? s1_dat_o : s0_dat_o), 32'(exp_d));
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [21:1] addr;
        logic [15:0] dat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, n, c0, c1, acks;
        int order [$];
        bit active [2];

        vecs[0] = '{port: 1'b0, wr: 1'b0, addr: 21'h00100, dat: 16'hF4E8};
        vecs[1] = '{port: 1'b1, wr: 1'b0, addr: 21'h00123, dat: flash_word(21'h00123)};
        vecs[2] = '{port: 1'b0, wr: 1'b1, addr: 21'h00200, dat: 16'hF4E8};
        vecs[3] = '{port: 1'b1, wr: 1'b1, addr: 21'h3FFFF, dat: flash_word(21'h00123)};
        vecs[4] = '{port: 1'b0, wr: 1'b0, addr: 21'h3FFFF, dat: flash_word(21'h3FFFF)};
        vecs[5] = '{port: 1'b1, wr: 1'b0, addr: 21'h00000, dat: flash_word(21'h00000)};

        drop_all();
        adr[0] = '0; adr[1] = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset NF_CE", 32'(NF_CE), 32'd1);
        chk("reset NF_OE", 32'(NF_OE), 32'd1);
        chk("reset NF_RP", 32'(NF_RP), 32'd0);
        chk("reset NF_A", 32'(NF_A), 32'd0);
        chk("reset s0_dat", 32'(s0_dat_o), 32'd0);
        chk("reset s1_dat", 32'(s1_dat_o), 32'd0);
        chk("reset acks", 32'({s0_ack_o, s1_ack_o}), 32'd0);
        rst = 1'b0;
        tick();
        chk("NF_RP after release", 32'(NF_RP), 32'd1);

        // Directed single transactions from the vector table.
        for (int i = 0; i < 6; i++)
            run_one(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].dat, $sformatf("vec%0d", i));

        // Simultaneous requests right after reset: port 0 first, port 1 seven cycles later.
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 21'h00010;
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 21'h00020;
        n = 0; t0 = -1; t1 = -1;
        while ((t0 < 0 || t1 < 0) && n < 60) begin
            tick();
            n++;
            if (s0_ack_o && t0 < 0) begin t0 = n; cyc[0] = 1'b0; stb[0] = 1'b0; end
            if (s1_ack_o && t1 < 0) begin t1 = n; cyc[1] = 1'b0; stb[1] = 1'b0; end
        end
        drop_all();
        chk("simul s0 latency", 32'(t0), 32'(WAIT + 2));
        chk("simul s1 after s0", 32'(t1 - t0), 32'(WAIT + 2));
        chk("simul s0_dat", 32'(s0_dat_o), 32'(flash_word(21'h00010)));
        chk("simul s1_dat", 32'(s1_dat_o), 32'(flash_word(21'h00020)));

        // Fairness: both ports requesting continuously for eight accesses.
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 21'h00555;
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 21'h00AAA;
        n = 0;
        while (order.size() < 8 && n < 200) begin
            tick();
            n++;
            if (s0_ack_o) order.push_back(0);
            if (s1_ack_o) order.push_back(1);
        end
        drop_all();
        chk("fair ack count", 32'(order.size()), 32'd8);
        c0 = 0; c1 = 0;
        foreach (order[i]) begin
            chk($sformatf("fair grant %0d", i), 32'(order[i]), 32'(i % 2));
            if (order[i] == 0) c0++; else c1++;
        end
        chk("fair s0 acks", 32'(c0), 32'd4);
        chk("fair s1 acks", 32'(c1), 32'd4);
        tick();

        // Abandoned access: s1 drops stb after two ACCESS cycles.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 21'h00055;
        tick();
        tick();
        tick();
        stb[1] = 1'b0;
        for (int i = 3; i <= WAIT; i++) begin
            tick();
            chk("abort no ack", 32'(s1_ack_o), 32'd0);
        end
        chk("abort ce released", 32'(NF_CE), 32'd1);
        tick();
        chk("abort no ack", 32'(s1_ack_o), 32'd0);
        cyc[1] = 1'b0;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 21'h00777;
        tick();
        chk("abort fsm idle, regrant", 32'(NF_CE), 32'd0);
        chk("abort s1_dat kept", 32'(s1_dat_o), 32'(flash_word(21'h00AAA)));
        n = 0;
        while (!s0_ack_o && n < 20) begin tick(); n++; end
        drop_all();
        chk("abort follow-up ack", 32'(s0_ack_o), 32'd1);
        tick();

        // Reset in the third ACCESS cycle, then a fresh read.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 21'h00300;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst NF_CE", 32'(NF_CE), 32'd1);
        chk("midrst NF_OE", 32'(NF_OE), 32'd1);
        chk("midrst NF_RP", 32'(NF_RP), 32'd0);
        chk("midrst NF_A", 32'(NF_A), 32'd0);
        chk("midrst s0_ack", 32'(s0_ack_o), 32'd0);
        chk("midrst s0_dat", 32'(s0_dat_o), 32'd0);
        drop_all();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post-rst no ack", 32'(s0_ack_o), 32'd0);
        end
        run_one(1'b0, 1'b0, 21'h3FFFF, flash_word(21'h3FFFF), "post-rst read");

        // Random traffic with abandonment; the per-cycle model does the checking.
        do_reset();
        active[0] = 1'b0; active[1] = 1'b0;
        acks = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                bit a;
                a = (p == 1) ? s1_ack_o : s0_ack_o;
                if (a) acks++;
                if (active[p]) begin
                    if (a || $urandom_range(0, 39) == 0) begin
                        stb[p] = 1'b0;
                        cyc[p] = a ? 1'b0 : 1'($urandom_range(0, 1));
                        active[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    active[p] = 1'b1;
                    cyc[p] = 1'b1;
                    stb[p] = 1'b1;
                    we[p]  = ($urandom_range(0, 3) == 0);
                    adr[p] = 21'($urandom);
                end
            end
        end
        drop_all();
        repeat (10) tick();
        chk("random traffic acks > 50", 32'(acks > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nor_flash_arbiter.md
NOR_FLASH_ARBITER -- requirements
Module: nor_flash_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 5, giving the flash access time in clock cycles (legal range 1..15).
REQ-002 The block SHALL have input wb_clk_i, 1 bit, the single system clock (50 MHz).
REQ-003 The block SHALL have input wb_rst_i, 1 bit, with asynchronous active-high reset.
REQ-004 The block SHALL have inputs s0_cyc_i, s0_stb_i, s0_we_i (1 bit each) and s0_adr_i [21:1], forming Wishbone port 0 (CPU) requests.
REQ-005 The block SHALL have outputs s0_dat_o [15:0] and s0_ack_o (1 bit), carrying port 0 read data and acknowledge.
REQ-006 The block SHALL have inputs s1_cyc_i, s1_stb_i, s1_we_i and s1_adr_i [21:1], and outputs s1_dat_o [15:0] and s1_ack_o, forming port 1 (secondary master), identical in shape to port 0.
REQ-007 The block SHALL have output NF_A [21:1], the flash word address.
REQ-008 The block SHALL have input NF_D [15:0], the flash data; the block never drives NF_D.
REQ-009 The block SHALL have outputs NF_CE, NF_OE and NF_WE, 1 bit each, active-low flash controls.
REQ-010 The block SHALL have outputs NF_BYTE and NF_RP, 1 bit each, giving word-mode select and active-low reset/powerdown.

Function
REQ-011 The request condition per port SHALL be sN_cyc_i & sN_stb_i.
REQ-012 The FSM SHALL have exactly three states: IDLE, ACCESS and ACK.
REQ-013 In IDLE with exactly one port requesting, the FSM SHALL grant that port at the clock edge and enter ACCESS.
REQ-014 In IDLE with both ports requesting, the FSM SHALL grant the port not granted last (round-robin); the first grant after reset goes to port 0.
REQ-015 On entering ACCESS, the block SHALL register the granted port's address onto NF_A and drive NF_CE=0 and NF_OE=0; for writes, NF_OE SHALL stay 1.
REQ-016 The wait counter SHALL be 4 bits, loaded with WAIT_CYCLES-1 on entering ACCESS and decremented each cycle; at count 0 the FSM SHALL enter ACK.
REQ-017 On the ACCESS-to-ACK edge of a read, the block SHALL latch NF_D into the granted port's dat_o; the other port's dat_o SHALL be unchanged.
REQ-018 In ACK, the block SHALL register the granted port's ack_o high for exactly one cycle, return NF_CE and NF_OE to 1, and return to IDLE on the next edge.
REQ-019 Read latency SHALL be: ack_o high in the cycle starting WAIT_CYCLES+1 edges after the edge that sampled the request.
REQ-020 A minimum of one IDLE cycle with NF_CE=1 SHALL separate consecutive accesses, including back-to-back accesses from the same port.
REQ-021 Writes (we_i=1) SHALL follow the same timing with NF_WE held at 1 (flash read-only), dat_o unchanged, and ack still returned.
REQ-022 If the granted port drops stb_i or cyc_i during ACCESS, the access SHALL complete on the flash, but no ack_o is issued and dat_o is unchanged.
REQ-023 A request arriving on the non-granted port during ACCESS or ACK SHALL be held pending and served from IDLE by the arbitration rule.
REQ-024 NF_BYTE SHALL be constant 1 (word mode).
REQ-025 NF_A SHALL hold its last value while in IDLE.
REQ-026 s0_ack_o and s1_ack_o SHALL never be high in the same cycle.

Reset
REQ-027 While wb_rst_i=1, the block SHALL hold state=IDLE, NF_CE=NF_OE=NF_WE=1, NF_RP=0, NF_A=0, both dat_o=0, both ack_o=0, and last-grant=port 1 (so port 0 wins first).
REQ-028 NF_RP SHALL go to 1 on the first clock edge after wb_rst_i deasserts.
REQ-029 Reset asserted mid-ACCESS SHALL force all outputs to their reset values immediately (asynchronously), with no ack issued for the aborted access.

Verification
REQ-030 The bench SHALL check a single read: WAIT_CYCLES=5, s0 read at 0x00100, flash returns 0xF4E8 -> NF_CE/NF_OE low for 5 cycles, s0_dat_o=0xF4E8, s0_ack_o high one cycle, 6 edges after the request.
REQ-031 The bench SHALL check simultaneous requests after reset: s0 reads 0x00010 and s1 reads 0x00020 -> s0 served first, then one IDLE cycle, then s1; s1_ack_o rises 7 cycles after s0_ack_o.
REQ-032 The bench SHALL check fairness: both ports requesting continuously for 8 accesses -> grants alternate 0,1,0,1,...; each port receives 4 acks.
REQ-033 The bench SHALL check an abandoned request: s1 drops stb after 2 ACCESS cycles -> no s1_ack_o, s1_dat_o unchanged, FSM back in IDLE after WAIT_CYCLES+1 cycles.
REQ-034 The bench SHALL check a write: s0 write -> NF_WE stays 1, NF_OE stays 1, s0_ack_o after WAIT_CYCLES+1, s0_dat_o unchanged.
REQ-035 The bench SHALL check reset mid-access: assert wb_rst_i in the third ACCESS cycle -> NF_CE=1 and NF_RP=0 in the same cycle, no ack; after release, a fresh read to 0x3FFFF completes normally.
